inst_fetch: RTL

INST_FETCH -- requirements
Module: inst_fetch

---
 rtl/inst_fetch.sv | 75 +++++++
 1 files changed

// File: rtl/inst_fetch.sv
// rtl/inst_fetch.sv - instruction fetch stage: PC register, IF/ID register, deferred branch redirect
module inst_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          DELAY_SLOT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        br_e,
    input  logic [31:0] br_target,
    output logic [31:0] inst_addr,
    input  logic [31:0] inst_data,
    output logic        id_valid,
    output logic [31:0] id_pc,
    output logic [31:0] id_inst,
    output logic        id_adel
);

    typedef enum logic [1:0] {BOOT, RUN, HOLD} state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] br_tgt;
    logic        br_pend;
    logic        adel_pend;
    logic        take;
    logic [31:0] tgt;

    // A fresh br_e outranks a branch held over from a stall: it is the newer target.
    always_comb begin
        take = br_e | br_pend;
        tgt  = br_e ? br_target : br_tgt;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= BOOT;
            pc        <= RESET_PC;
            br_tgt    <= 32'h0;
            br_pend   <= 1'b0;
            adel_pend <= 1'b0;
            id_valid  <= 1'b0;
            id_pc     <= 32'h0;
            id_inst   <= 32'h0;
            id_adel   <= 1'b0;
        end else begin
            case (state)
                BOOT: state <= RUN;
                RUN, HOLD: begin
                    if (stall) begin
                        state <= HOLD;
                        if (br_e) begin
                            br_pend <= 1'b1;
                            br_tgt  <= br_target;
                        end
                    end else begin
                        state    <= RUN;
                        id_valid <= (DELAY_SLOT != 0) || !take;
                        id_pc    <= pc;
                        id_inst  <= inst_data;
                        // adel follows the first word fetched from a misaligned redirect
                        id_adel   <= adel_pend;
                        adel_pend <= take && (tgt[1:0] != 2'b00);
                        pc        <= take ? {tgt[31:2], 2'b00} : pc + 32'd4;
                        br_pend   <= 1'b0;
                    end
                end
                default: state <= BOOT;
            endcase
        end
    end

    assign inst_addr = pc;

endmodule
